// File: rtl/fft_addr_sched.sv
// Address and stage scheduler for an in-place radix-2 DIT FFT: bit-reversed load
// addressing, then a butterfly-by-butterfly walk of every stage gated by write-back acks.
module fft_addr_sched #(
  parameter  int N_POINTS = 16,
  localparam int LOG2N    = $clog2(N_POINTS),
  localparam int STAGE_W  = ($clog2(LOG2N) > 0 ? $clog2(LOG2N) : 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               sample_valid_i,
  input  logic               bfly_ack_i,
  output logic               load_ready_o,
  output logic [LOG2N-1:0]   wr_addr_o,
  output logic               bfly_valid_o,
  output logic [LOG2N-1:0]   addr_a_o,
  output logic [LOG2N-1:0]   addr_b_o,
  output logic [LOG2N-2:0]   tw_addr_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               end_load_o,
  output logic               end_algo_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, BFLY, DONE} state_e;

  state_e             state_q, state_d;
  logic [LOG2N:0]     cnt;
  logic [STAGE_W-1:0] s;
  logic [LOG2N-2:0]   k;

  logic               last_sample, last_k, last_stage;
  logic [LOG2N-1:0]   k_ext, half, pos, a_addr, tw_full;
  logic [STAGE_W:0]   a_sh, tw_sh;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  assign last_sample = (cnt == (LOG2N+1)'(N_POINTS - 1));
  assign last_k      = &k;
  assign last_stage  = (s == STAGE_W'(LOG2N - 1));

  // Butterfly geometry for stage s, butterfly k
  always_comb begin
    k_ext   = {1'b0, k};
    half    = LOG2N'(1) << s;
    pos     = k_ext & (half - LOG2N'(1));
    a_sh    = {1'b0, s} + (STAGE_W+1)'(1);
    tw_sh   = (STAGE_W+1)'(LOG2N - 1) - {1'b0, s};
    a_addr  = ((k_ext >> s) << a_sh) | pos;
    tw_full = pos << tw_sh;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_d = LOAD;
        LOAD: if (sample_valid_i && last_sample) state_d = BFLY;
        BFLY: if (bfly_ack_i && last_k && last_stage) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt     <= '0;
      s       <= '0;
      k       <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i || (state_q == IDLE && start_i)) begin
        cnt <= '0;
        s   <= '0;
        k   <= '0;
      end else if (state_q == LOAD && sample_valid_i) begin
        cnt <= cnt + (LOG2N+1)'(1);
      end else if (state_q == BFLY && bfly_ack_i) begin
        if (last_k) begin
          k <= '0;
          s <= s + STAGE_W'(1);
        end else begin
          k <= k + (LOG2N-1)'(1);
        end
      end
    end
  end

  assign load_ready_o = (state_q == LOAD);
  assign bfly_valid_o = (state_q == BFLY);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign wr_addr_o    = load_ready_o ? bit_rev(cnt[LOG2N-1:0]) : '0;
  assign addr_a_o     = bfly_valid_o ? a_addr : '0;
  assign addr_b_o     = bfly_valid_o ? (a_addr + half) : '0;
  assign tw_addr_o    = bfly_valid_o ? tw_full[LOG2N-2:0] : '0;
  assign stage_o      = s;
  assign end_load_o   = load_ready_o && sample_valid_i && last_sample;
  assign end_algo_o   = bfly_valid_o && last_k && last_stage;

endmodule

// File: tb/tb_fft_addr_sched.sv
// Directed bench for fft_addr_sched at N_POINTS=8: load reversal, address walk,
// stalls, gapped load, clear and asynchronous reset.
module tb_fft_addr_sched;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       sample_valid_i = 1'b0;
  logic       bfly_ack_i = 1'b0;
  logic       load_ready_o;
  logic [2:0] wr_addr_o;
  logic       bfly_valid_o;
  logic [2:0] addr_a_o;
  logic [2:0] addr_b_o;
  logic [1:0] tw_addr_o;
  logic [1:0] stage_o;
  logic       end_load_o;
  logic       end_algo_o;
  logic       busy_o;
  logic       done_o;

  int vectors = 0;
  int errors  = 0;

  logic [2:0] exp_wr [8]  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic [2:0] exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  logic [2:0] exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  logic [1:0] exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  fft_addr_sched #(.N_POINTS(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
    .sample_valid_i(sample_valid_i), .bfly_ack_i(bfly_ack_i),
    .load_ready_o(load_ready_o), .wr_addr_o(wr_addr_o), .bfly_valid_o(bfly_valid_o),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .tw_addr_o(tw_addr_o),
    .stage_o(stage_o), .end_load_o(end_load_o), .end_algo_o(end_algo_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Start a transform and feed 8 back-to-back samples; leaves the DUT in BFLY.
  task automatic do_load();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    sample_valid_i = 1'b1;
    repeat (8) tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({load_ready_o, wr_addr_o, bfly_valid_o, addr_a_o, addr_b_o, tw_addr_o, stage_o,
         end_load_o, end_algo_o, busy_o, done_o} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {load_ready_o, wr_addr_o, bfly_valid_o, addr_a_o, addr_b_o, tw_addr_o,
                stage_o, end_load_o, end_algo_o, busy_o, done_o});
    end
    #3 rst_ni = 1'b1;
    tick();
    vectors++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy_o=%b want 0", busy_o);
    end
  endtask

  task automatic test_load_bitrev();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    vectors++;
    if (load_ready_o !== 1'b1 || wr_addr_o !== 3'd0) begin
      errors++;
      $display("FAIL load_entry: load_ready=%b wr_addr=%0d want 1,0", load_ready_o, wr_addr_o);
    end
    for (int i = 0; i < 8; i++) begin
      sample_valid_i = 1'b1;
      #1;
      vectors++;
      if (wr_addr_o !== exp_wr[i] || end_load_o !== (i == 7)) begin
        errors++;
        $display("FAIL load_addr[%0d]: wr_addr=%0d end_load=%b want %0d,%b",
                 i, wr_addr_o, end_load_o, exp_wr[i], (i == 7));
      end
      tick();
    end
    sample_valid_i = 1'b0;
    #1;
    vectors++;
    if (bfly_valid_o !== 1'b1 || load_ready_o !== 1'b0 || wr_addr_o !== 3'd0) begin
      errors++;
      $display("FAIL load_exit: bfly_valid=%b load_ready=%b wr_addr=%0d want 1,0,0",
               bfly_valid_o, load_ready_o, wr_addr_o);
    end
  endtask

  task automatic test_addr_walk();
    for (int i = 0; i < 12; i++) begin
      bfly_ack_i = 1'b1;
      #1;
      vectors++;
      if (addr_a_o !== exp_a[i] || addr_b_o !== exp_b[i] || tw_addr_o !== exp_tw[i] ||
          stage_o !== 2'(i / 4) || end_algo_o !== (i == 11) || bfly_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL walk[%0d]: a=%0d b=%0d tw=%0d s=%0d ea=%b want %0d,%0d,%0d,%0d,%b",
                 i, addr_a_o, addr_b_o, tw_addr_o, stage_o, end_algo_o,
                 exp_a[i], exp_b[i], exp_tw[i], i / 4, (i == 11));
      end
      tick();
    end
    bfly_ack_i = 1'b0;
    vectors++;
    if (done_o !== 1'b1 || bfly_valid_o !== 1'b0 || addr_a_o !== 3'd0) begin
      errors++;
      $display("FAIL walk_done: done=%b bfly_valid=%b a=%0d want 1,0,0",
               done_o, bfly_valid_o, addr_a_o);
    end
    tick();
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL walk_idle: done=%b busy=%b want 0,0", done_o, busy_o);
    end
  endtask

  task automatic test_stall();
    do_load();
    bfly_ack_i = 1'b1;
    repeat (4) tick();
    bfly_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (addr_a_o !== 3'd0 || addr_b_o !== 3'd2 || stage_o !== 2'd1 || end_algo_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_s1[%0d]: a=%0d b=%0d s=%0d ea=%b want 0,2,1,0",
                 i, addr_a_o, addr_b_o, stage_o, end_algo_o);
      end
      tick();
    end
    bfly_ack_i = 1'b1;
    repeat (7) tick();
    bfly_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (addr_a_o !== 3'd3 || addr_b_o !== 3'd7 || tw_addr_o !== 2'd3 ||
          stage_o !== 2'd2 || end_algo_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_last[%0d]: a=%0d b=%0d tw=%0d s=%0d ea=%b done=%b want 3,7,3,2,1,0",
                 i, addr_a_o, addr_b_o, tw_addr_o, stage_o, end_algo_o, done_o);
      end
      tick();
    end
    bfly_ack_i = 1'b1;
    tick();
    bfly_ack_i = 1'b0;
    vectors++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: done=%b want 1", done_o);
    end
    tick();
  endtask

  task automatic test_gapped_load();
    start_i = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      sample_valid_i = 1'b1;
      start_i = 1'b0;
      #1;
      vectors++;
      if (wr_addr_o !== exp_wr[i] || end_load_o !== (i == 7)) begin
        errors++;
        $display("FAIL gap_addr[%0d]: wr_addr=%0d end_load=%b want %0d,%b",
                 i, wr_addr_o, end_load_o, exp_wr[i], (i == 7));
      end
      tick();
      sample_valid_i = 1'b0;
      start_i = 1'b1;
      if (i < 7) begin
        #1;
        vectors++;
        if (wr_addr_o !== exp_wr[i+1] || load_ready_o !== 1'b1 || bfly_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL gap_hold[%0d]: wr_addr=%0d load_ready=%b bfly_valid=%b want %0d,1,0",
                   i, wr_addr_o, load_ready_o, bfly_valid_o, exp_wr[i+1]);
        end
        tick();
      end
    end
    start_i = 1'b0;
    vectors++;
    if (bfly_valid_o !== 1'b1 || addr_b_o !== 3'd1) begin
      errors++;
      $display("FAIL gap_bfly: bfly_valid=%b b=%0d want 1,1", bfly_valid_o, addr_b_o);
    end
    bfly_ack_i = 1'b1;
    repeat (12) tick();
    bfly_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    do_load();
    bfly_ack_i = 1'b1;
    repeat (5) tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    bfly_ack_i = 1'b0;
    vectors++;
    if ({load_ready_o, wr_addr_o, bfly_valid_o, addr_a_o, addr_b_o, tw_addr_o, stage_o,
         end_load_o, end_algo_o, busy_o, done_o} !== 20'd0) begin
      errors++;
      $display("FAIL clear_idle: got %b, want all zero",
               {load_ready_o, wr_addr_o, bfly_valid_o, addr_a_o, addr_b_o, tw_addr_o,
                stage_o, end_load_o, end_algo_o, busy_o, done_o});
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    vectors++;
    if (load_ready_o !== 1'b1 || wr_addr_o !== 3'd0) begin
      errors++;
      $display("FAIL clear_restart: load_ready=%b wr_addr=%0d want 1,0", load_ready_o, wr_addr_o);
    end
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    vectors++;
    if (wr_addr_o !== 3'd4) begin
      errors++;
      $display("FAIL clear_second: wr_addr=%0d want 4", wr_addr_o);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if (load_ready_o !== 1'b0 || wr_addr_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: load_ready=%b wr_addr=%0d busy=%b want 0,0,0",
               load_ready_o, wr_addr_o, busy_o);
    end
    #2 rst_ni = 1'b1;
    tick();
    do_load();
    start_i = 1'b1;
    tick();
    tick();
    start_i = 1'b0;
    vectors++;
    if (bfly_valid_o !== 1'b1 || stage_o !== 2'd0 || addr_a_o !== 3'd0 || addr_b_o !== 3'd1) begin
      errors++;
      $display("FAIL start_in_bfly: bfly_valid=%b s=%0d a=%0d b=%0d want 1,0,0,1",
               bfly_valid_o, stage_o, addr_a_o, addr_b_o);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_bitrev();
    test_addr_walk();
    test_stall();
    test_gapped_load();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
